// File: rtl/lobby_if.sv
// Peer handshake wires between boards: ready/start broadcast out, peer reports in.
interface lobby_if;
  logic peer_ready_in;
  logic peer_start_in;
  logic ready_out;
  logic start_out;

  modport master (input peer_ready_in, peer_start_in, output ready_out, start_out);
  modport slave  (output peer_ready_in, peer_start_in, input ready_out, start_out);
endinterface

// File: rtl/lobby_controller.sv
// Lobby/start controller: start-code entry, player-ID latch, ready/start handshake
// and a multiplexed 4-digit seven-segment display.
module lobby_controller #(
  parameter int          CODE_LEN    = 3,
  parameter logic [15:0] CODE        = 16'h0206,
  parameter bit          STRICT      = 1'b1,
  parameter int          NUM_PLAYERS = 2,
  parameter int          HOLD_TICKS  = 400,
  parameter int          SCAN_DIV    = 31250,
  localparam int         PID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                clk_6p25,
  input  logic                reset_n,
  input  logic [9:0]          digit_sw,
  input  logic [PID_W-1:0]    player_sel,
  input  logic                btn_start,
  lobby_if.master             peer,
  output logic                start,
  output logic [PID_W-1:0]    player_id,
  output logic                code_ok,
  output logic [CODE_LEN-1:0] led_progress,
  output logic [6:0]          seg,
  output logic [3:0]          an,
  output logic                dp
);

  localparam logic [1:0] ST_ENTRY   = 2'd0;
  localparam logic [1:0] ST_SHOW    = 2'd1;
  localparam logic [1:0] ST_LOBBY   = 2'd2;
  localparam logic [1:0] ST_STARTED = 2'd3;

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  logic [1:0]        state_reg;
  logic [2:0]        ptr_reg;
  logic [SCAN_W-1:0] scan_cnt_reg;
  logic [1:0]        scan_idx_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [9:0]        sw_prev_reg;
  logic [1:0]        btn_sync_reg;
  logic [1:0]        rdy_sync_reg;
  logic [1:0]        sts_sync_reg;
  logic              btn_prev_reg;
  logic [PID_W-1:0]  player_id_reg;
  logic [6:0]        seg_reg;
  logic [3:0]        an_reg;

  logic [3:0] code_digit [4];
  logic [9:0] sw_rise;
  logic       digit_match;
  logic       digit_wrong;
  logic       scan_tick;
  logic       btn_edge;
  logic [6:0] seg_next;

  // Digit 0 sits in the most significant used nibble.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_code
      if (gi < CODE_LEN) begin : g_used
        assign code_digit[gi] = CODE[4*(CODE_LEN-gi)-1 -: 4];
      end else begin : g_unused
        assign code_digit[gi] = 4'hF;
      end
    end
    for (gi = 0; gi < CODE_LEN; gi++) begin : g_led
      assign led_progress[gi] = (ptr_reg > 3'(gi));
    end
  endgenerate

  // A multi-bit rise can never equal a one-hot target, so it is always wrong.
  assign sw_rise     = digit_sw & ~sw_prev_reg;
  assign digit_match = (sw_rise != 10'd0) && (sw_rise == (10'd1 << code_digit[ptr_reg[1:0]]));
  assign digit_wrong = (sw_rise != 10'd0) && !digit_match;
  assign scan_tick   = (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1));
  assign btn_edge    = btn_sync_reg[1] & ~btn_prev_reg;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  always_comb begin
    seg_next = 7'h7F;
    case (state_reg)
      ST_ENTRY: if ({1'b0, scan_idx_reg} < ptr_reg) seg_next = hex7(code_digit[scan_idx_reg]);
      ST_SHOW:  if (int'(scan_idx_reg) < CODE_LEN)  seg_next = hex7(code_digit[scan_idx_reg]);
      default: begin
        if (scan_idx_reg == 2'd0)      seg_next = 7'h0C;
        else if (scan_idx_reg == 2'd1) seg_next = hex7(4'(player_id_reg));
      end
    endcase
  end

  always_ff @(posedge clk_6p25) begin
    if (!reset_n) begin
      state_reg     <= ST_ENTRY;
      ptr_reg       <= 3'd0;
      scan_cnt_reg  <= '0;
      scan_idx_reg  <= 2'd0;
      hold_cnt_reg  <= '0;
      sw_prev_reg   <= 10'd0;
      btn_sync_reg  <= 2'd0;
      rdy_sync_reg  <= 2'd0;
      sts_sync_reg  <= 2'd0;
      btn_prev_reg  <= 1'b0;
      player_id_reg <= '0;
      seg_reg       <= 7'h7F;
      an_reg        <= 4'hF;
    end else begin
      sw_prev_reg  <= digit_sw;
      btn_sync_reg <= {btn_sync_reg[0], btn_start};
      rdy_sync_reg <= {rdy_sync_reg[0], peer.peer_ready_in};
      sts_sync_reg <= {sts_sync_reg[0], peer.peer_start_in};
      btn_prev_reg <= btn_sync_reg[1];

      if (scan_tick) begin
        scan_cnt_reg <= '0;
        scan_idx_reg <= scan_idx_reg + 2'd1;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
      end

      if (state_reg != ST_STARTED) begin
        if (int'(player_sel) >= NUM_PLAYERS) player_id_reg <= PID_W'(NUM_PLAYERS - 1);
        else                                 player_id_reg <= player_sel;
      end

      case (state_reg)
        ST_ENTRY: begin
          if (digit_match) begin
            ptr_reg <= ptr_reg + 3'd1;
            if (int'(ptr_reg) == CODE_LEN - 1) begin
              state_reg    <= ST_SHOW;
              hold_cnt_reg <= '0;
            end
          end else if (digit_wrong && STRICT) begin
            ptr_reg <= 3'd0;
          end
        end
        ST_SHOW: begin
          if (scan_tick) begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
            if (hold_cnt_reg == HOLD_W'(HOLD_TICKS - 1)) state_reg <= ST_LOBBY;
          end
        end
        ST_LOBBY: begin
          // Host needs the peer ready at the moment of the press; early presses are lost.
          if (player_id_reg == '0) begin
            if (btn_edge && rdy_sync_reg[1]) state_reg <= ST_STARTED;
          end else if (sts_sync_reg[1]) begin
            state_reg <= ST_STARTED;
          end
        end
        default: state_reg <= ST_STARTED;
      endcase

      seg_reg <= seg_next;
      an_reg  <= ~(4'b1000 >> scan_idx_reg);
    end
  end

  assign start          = (state_reg == ST_STARTED);
  assign peer.start_out = start && (player_id_reg == '0);
  assign peer.ready_out = state_reg[1];
  assign code_ok        = (state_reg != ST_ENTRY);
  assign player_id      = player_id_reg;
  assign seg            = seg_reg;
  assign an             = an_reg;
  assign dp             = 1'b1;

endmodule

// File: tb/tb_lobby_controller.sv
// Directed bench: three controller instances (strict, lenient, 4-player/4-digit)
// sharing one clock and reset, checked against hand-computed values.
module tb_lobby_controller;

  logic       clk_6p25;
  logic       reset_n;
  logic [9:0] sw_a, sw_b, sw_c;
  logic       psel_a, psel_b;
  logic [1:0] psel_c;
  logic       btn_a, btn_b, btn_c;
  logic       start_a, start_b, start_c;
  logic       pid_a, pid_b;
  logic [1:0] pid_c;
  logic       ok_a, ok_b, ok_c;
  logic [2:0] led_a, led_b;
  logic [3:0] led_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [3:0] an_a, an_b, an_c;
  logic       dp_a, dp_b, dp_c;

  lobby_if a_if ();
  lobby_if b_if ();
  lobby_if c_if ();

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  lobby_controller #(.SCAN_DIV(4), .HOLD_TICKS(20)) u_a (
    .clk_6p25(clk_6p25), .reset_n(reset_n), .digit_sw(sw_a), .player_sel(psel_a),
    .btn_start(btn_a), .peer(a_if.master), .start(start_a), .player_id(pid_a),
    .code_ok(ok_a), .led_progress(led_a), .seg(seg_a), .an(an_a), .dp(dp_a));

  lobby_controller #(.STRICT(1'b0), .SCAN_DIV(4), .HOLD_TICKS(20)) u_b (
    .clk_6p25(clk_6p25), .reset_n(reset_n), .digit_sw(sw_b), .player_sel(psel_b),
    .btn_start(btn_b), .peer(b_if.master), .start(start_b), .player_id(pid_b),
    .code_ok(ok_b), .led_progress(led_b), .seg(seg_b), .an(an_b), .dp(dp_b));

  lobby_controller #(.CODE_LEN(4), .CODE(16'h1234), .NUM_PLAYERS(4),
                     .SCAN_DIV(4), .HOLD_TICKS(20)) u_c (
    .clk_6p25(clk_6p25), .reset_n(reset_n), .digit_sw(sw_c), .player_sel(psel_c),
    .btn_start(btn_c), .peer(c_if.master), .start(start_c), .player_id(pid_c),
    .code_ok(ok_c), .led_progress(led_c), .seg(seg_c), .an(an_c), .dp(dp_c));

  initial clk_6p25 = 1'b0;
  always #5 clk_6p25 = ~clk_6p25;
  always @(posedge clk_6p25) cyc++;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("  ok %s: %0h", tag, got);
    end
  endtask

  function automatic logic [3:0] get_an(input int u);
    case (u)
      0: return an_a;
      1: return an_b;
      default: return an_c;
    endcase
  endfunction

  function automatic logic [6:0] get_seg(input int u);
    case (u)
      0: return seg_a;
      1: return seg_b;
      default: return seg_c;
    endcase
  endfunction

  function automatic logic get_ready(input int u);
    case (u)
      0: return a_if.ready_out;
      1: return b_if.ready_out;
      default: return c_if.ready_out;
    endcase
  endfunction

  // One switch pattern held for exactly one sampling edge, then released.
  task automatic press(input int u, input logic [9:0] bits);
    @(negedge clk_6p25);
    case (u)
      0: sw_a = bits;
      1: sw_b = bits;
      default: sw_c = bits;
    endcase
    @(negedge clk_6p25);
    sw_a = 10'd0; sw_b = 10'd0; sw_c = 10'd0;
  endtask

  task automatic wait_ready(input int u, input string tag);
    int n = 0;
    while (get_ready(u) !== 1'b1 && n < 300) begin
      @(negedge clk_6p25);
      n++;
    end
    check_eq(tag, int'(get_ready(u)), 1);
  endtask

  task automatic show_chk(input int u, input logic [3:0] a, input logic [6:0] s, input string tag);
    int n = 0;
    while (get_an(u) !== a && n < 40) begin
      @(negedge clk_6p25);
      n++;
    end
    check_eq({tag, "_an"}, int'(get_an(u)), int'(a));
    check_eq({tag, "_seg"}, int'(get_seg(u)), int'(s));
  endtask

  logic [3:0] an_seq [4];
  int         t0;
  int         dt;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    an_seq = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    reset_n = 1'b0;
    sw_a = '0; sw_b = '0; sw_c = '0;
    psel_a = 1'b0; psel_b = 1'b1; psel_c = 2'd3;
    btn_a = 0; btn_b = 0; btn_c = 0;
    a_if.peer_ready_in = 0; a_if.peer_start_in = 0;
    b_if.peer_ready_in = 0; b_if.peer_start_in = 0;
    c_if.peer_ready_in = 0; c_if.peer_start_in = 0;
    repeat (3) @(negedge clk_6p25);

    check_eq("rst_seg", int'(seg_a), 'h7F);
    check_eq("rst_an", int'(an_a), 'hF);
    check_eq("rst_dp", int'(dp_a), 1);
    check_eq("rst_start", int'(start_a), 0);
    check_eq("rst_ready", int'(a_if.ready_out), 0);
    check_eq("rst_code_ok", int'(ok_a), 0);
    check_eq("rst_led", int'(led_a), 0);
    reset_n = 1'b1;

    // Strict instance: wrong digit and double edge both clear progress
    press(0, 10'b0000000100); check_eq("a_led_2", int'(led_a), 'b001);
    press(0, 10'b0000100000); check_eq("a_led_wrong5", int'(led_a), 'b000);
    press(0, 10'b0000000100); check_eq("a_led_2b", int'(led_a), 'b001);
    press(0, 10'b0000000101); check_eq("a_led_double", int'(led_a), 'b000);
    press(0, 10'b0000000100); check_eq("a_led_d0", int'(led_a), 'b001);
    press(0, 10'b0000000001); check_eq("a_led_d1", int'(led_a), 'b011);
    press(0, 10'b0001000000); check_eq("a_led_d2", int'(led_a), 'b111);
    t0 = cyc;
    check_eq("a_code_ok", int'(ok_a), 1);
    show_chk(0, 4'b0111, 7'h24, "a_show0");
    show_chk(0, 4'b1011, 7'h40, "a_show1");
    show_chk(0, 4'b1101, 7'h02, "a_show2");
    show_chk(0, 4'b1110, 7'h7F, "a_show3");
    check_eq("a_ready_in_show", int'(a_if.ready_out), 0);
    wait_ready(0, "a_lobby");
    dt = cyc - t0;
    check_eq("a_hold_77_80", int'(dt >= 77 && dt <= 80), 1);
    show_chk(0, 4'b0111, 7'h0C, "a_lobby_p");
    show_chk(0, 4'b1011, 7'h40, "a_lobby_id");

    // Host: press without a ready peer is discarded
    @(negedge clk_6p25); btn_a = 1;
    repeat (6) @(negedge clk_6p25);
    check_eq("a_btn_no_peer", int'(start_a), 0);
    btn_a = 0;
    a_if.peer_ready_in = 1;
    repeat (4) @(negedge clk_6p25);
    btn_a = 1;
    repeat (2) @(negedge clk_6p25);
    check_eq("a_start_cyc2", int'(start_a), 0);
    @(negedge clk_6p25);
    check_eq("a_start_cyc3", int'(start_a), 1);
    check_eq("a_start_out", int'(a_if.start_out), 1);
    btn_a = 0;

    // Lenient instance, non-host
    press(1, 10'b0000000100); check_eq("b_led_2", int'(led_b), 'b001);
    press(1, 10'b0000100000); check_eq("b_led_wrong5", int'(led_b), 'b001);
    press(1, 10'b0000000001); check_eq("b_led_0", int'(led_b), 'b011);
    press(1, 10'b0001000000); check_eq("b_led_6", int'(led_b), 'b111);
    wait_ready(1, "b_lobby");
    show_chk(1, 4'b0111, 7'h0C, "b_lobby_p");
    show_chk(1, 4'b1011, 7'h79, "b_lobby_id");
    @(negedge clk_6p25); btn_b = 1;
    repeat (6) @(negedge clk_6p25);
    check_eq("b_btn_ignored", int'(start_b), 0);
    btn_b = 0;
    b_if.peer_start_in = 1;
    repeat (2) @(negedge clk_6p25);
    check_eq("b_start_cyc2", int'(start_b), 0);
    @(negedge clk_6p25);
    check_eq("b_start_cyc3", int'(start_b), 1);
    check_eq("b_start_out", int'(b_if.start_out), 0);
    check_eq("b_ready", int'(b_if.ready_out), 1);
    psel_b = 0;
    repeat (3) @(negedge clk_6p25);
    check_eq("b_pid_frozen", int'(pid_b), 1);

    // 4-player, 4-digit instance
    press(2, 10'b0000000010); check_eq("c_led_1", int'(led_c), 'b0001);
    press(2, 10'b0000000100); check_eq("c_led_2", int'(led_c), 'b0011);
    press(2, 10'b0000001000); check_eq("c_led_3", int'(led_c), 'b0111);
    press(2, 10'b0000010000); check_eq("c_led_4", int'(led_c), 'b1111);
    wait_ready(2, "c_lobby");
    check_eq("c_pid", int'(pid_c), 3);
    show_chk(2, 4'b0111, 7'h0C, "c_lobby_p");
    show_chk(2, 4'b1011, 7'h30, "c_lobby_id");
    for (int k = 0; k < 8; k++) begin
      repeat (4) @(negedge clk_6p25);
      check_eq("c_scan_an", int'(an_c), int'(an_seq[(k + 2) % 4]));
    end

    // Mid-game reset on the started host
    @(negedge clk_6p25); reset_n = 0;
    @(negedge clk_6p25);
    check_eq("a_rst_start", int'(start_a), 0);
    check_eq("a_rst_start_out", int'(a_if.start_out), 0);
    check_eq("a_rst_an", int'(an_a), 'hF);
    check_eq("a_rst_led", int'(led_a), 0);
    reset_n = 1;
    press(0, 10'b0000000100);
    press(0, 10'b0000000001);
    press(0, 10'b0001000000);
    check_eq("a_reentry_led", int'(led_a), 'b111);
    check_eq("a_reentry_ok", int'(ok_a), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lobby_controller.md
Name: lobby_controller

Overview:
- Parametrised lobby/start controller: entry of an N-digit start code via digit switches, player-ID latch, and a multiplexed 4-digit seven-segment display driver.
- Handles the ready/start handshake between the host board (player 0) and peer boards over two Pmod wires.
- Sits between board I/O (switches, button, Pmod) and game logic; asserts `start` when play begins.

Parameters:
- CODE_LEN, 3, number of code digits (1..4).
- CODE, 16'h0206, packed code digits, 4 bits each; digit 0 is the first to enter and sits in CODE[4*CODE_LEN-1 -: 4]. The default is code 2-0-6.
- STRICT, 1, 1 = a wrong digit resets progress to 0; 0 = a wrong digit is ignored.
- NUM_PLAYERS, 2, number of player IDs; PID_W = max(1, clog2(NUM_PLAYERS)).
- HOLD_TICKS, 400, number of scan ticks the full code is shown before switching to the player display.
- SCAN_DIV, 31250, clock cycles per scan tick (digit refresh).

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- digit_sw  in  10  switch k enters decimal digit k on its 0->1 edge
- player_sel  in  PID_W  requested player ID
- btn_start  in  1  start button (host only)
- peer_ready_in  in  1  peer reports ready
- peer_start_in  in  1  host reports start
- ready_out  out  1  this board is ready
- start_out  out  1  start broadcast
- start  out  1  game running
- player_id  out  PID_W  latched player ID
- code_ok  out  1  full code accepted
- led_progress  out  CODE_LEN  thermometer of matched digits
- seg  out  7  active-low segments, gfedcba
- an  out  4  active-low anodes, an[3] is the leftmost digit
- dp  out  1  decimal point, constant 1

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=ENTRY, ptr=0, scan/hold counters 0.
  - All outputs 0 except seg=7'h7F, an=4'hF, dp=1.
  - Reset mid-game returns to ENTRY and deasserts start/start_out the next cycle.
- Synchronisers: btn_start, peer_ready_in, peer_start_in each pass through 2 flops; btn_start is then edge-detected. This adds 2 cycles of latency; a held button counts once.
- digit_sw edge detection uses the registered previous value.
  - More than one rising bit in the same cycle is a wrong digit.
  - Edges are ignored outside ENTRY.
- ENTRY:
  - Single rising bit k equal to code digit[ptr]: ptr+1.
  - Wrong digit: ptr=0 if STRICT, else unchanged.
  - A correct digit that completes the code (ptr reaches CODE_LEN) moves to SHOW_CODE the next cycle, and the hold counter clears.
- Progress and code_ok:
  - led_progress[i] = (ptr > i).
  - code_ok = 1 from SHOW_CODE onward.
- player_id follows player_sel every cycle until STARTED, then freezes; values >= NUM_PLAYERS saturate to NUM_PLAYERS-1.
- SHOW_CODE: hold counter increments per scan tick; at HOLD_TICKS it moves to LOBBY.
- LOBBY:
  - ready_out=1.
  - Host (player_id==0): synced peer_ready_in==1 and a btn edge in the same cycle -> STARTED. A btn edge while the peer is not ready is discarded.
  - Non-host: synced peer_start_in==1 -> STARTED; btn is ignored.
- STARTED:
  - start=1.
  - start_out=1 on host, 0 on non-host.
  - ready_out stays 1.
  - Terminal until reset.
- Scan:
  - Tick every SCAN_DIV cycles; a 2-bit digit index increments per tick and wraps 3->0.
  - an = one-hot-low of the index, registered with seg.
- Display content, left-aligned at an[3]:
  - ENTRY: digits 0..ptr-1 show code digits; other positions blank (7F).
  - SHOW_CODE: all CODE_LEN digits; the rest blank.
  - LOBBY/STARTED: an[3]="P" (0001100), an[2]=player_id as a hex digit; the rest blank.
- Glyphs:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A-F in standard hex.

Test Plan:
- Defaults (SCAN_DIV=4, HOLD_TICKS=20): rise sw[2], then sw[0], then sw[6] -> led_progress 001, 011, 111 (progress after 1, 2, 3 digits); SHOW_CODE shows 2,0,6 on an[3..1]; LOBBY follows after 20 ticks (80 cycles); code_ok=1.
- STRICT=1: enter 2, then 5 -> ptr=0, led 000; then 2,0,6 succeeds. STRICT=0: enter 2,5,0,6 -> accepted. Rising sw[2] and sw[0] in the same cycle -> treated as a wrong digit.
- Host in LOBBY: btn pulse with peer_ready_in=0 -> stays LOBBY. Set peer_ready_in=1, then btn pulse -> start=1 and start_out=1 exactly 3 cycles after the btn edge at the pin.
- Non-host (player_sel=1): LOBBY shows "P","1"; ready_out=1; btn is ignored. Raise peer_start_in -> start=1 after 3 cycles. Toggling player_sel afterwards leaves player_id=1.
- Reset_n=0 for 1 cycle while in STARTED -> start=0, an=F, ptr=0 the next cycle; code re-entry works.
- NUM_PLAYERS=4, CODE_LEN=4, CODE=16'h1234: enter 1,2,3,4 -> accepted; player_sel=3 shows "P","3"; scan an sequence 0111, 1011, 1101, 1110, repeating.
